pixel_stream_framer: RTL and testbench

PIXEL_STREAM_FRAMER -- requirements
Module: pixel_stream_framer

---
 rtl/pixel_stream_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/pixel_stream_framer.sv | 154 +++++++++++++++
 tb/tb_pixel_stream_framer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream framer.
//   IMG_W_DEFAULT / IMG_H_DEFAULT : default raster size (pixels per row, rows per frame)
//   beat_t                        : one buffered output beat {data, sof, eol, eof}
//   state_t                       : framer state machine encoding
package pixel_stream_pkg;

    localparam int IMG_W_DEFAULT = 3124;
    localparam int IMG_H_DEFAULT = 3030;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage.
//   clk, rst        : clock, synchronous active-high reset (clears pointers)
//   i_push, i_data  : write request and data; accepted when not full, or when
//                     a pop happens in the same cycle
//   i_pop           : read request; ignored while empty
//   o_data          : head entry (don't-care while empty)
//   o_full, o_empty : occupancy flags
// Reads come straight from the storage array, so nothing written this cycle
// can reach o_data before the next edge.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being written is the one being read out this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/pixel_stream_framer.sv
// Tags a raw pixel stream with raster position and buffers it for a
// downstream consumer.
//   clk, rst          : clock, synchronous active-high reset
//   pix_in, pix_valid : incoming pixel; the source cannot be stalled
//   m_data, m_sof, m_eol, m_eof, m_valid, m_ready : output beat stream
//   frame_done        : one-cycle pulse after the last pixel of a frame is sampled
//   overflow          : sticky, set when any pixel is dropped
//   clr_overflow      : clears overflow and drop_cnt (a same-cycle drop wins)
//   drop_cnt          : saturating count of dropped pixels
// Handshake: a beat transfers on every rising edge where m_valid && m_ready;
// while m_valid && !m_ready the beat holds steady; m_valid is FIFO not-empty.
module pixel_stream_framer
    import pixel_stream_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEFAULT,
    parameter int IMG_H      = IMG_H_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic [7:0]  m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_eof,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        frame_done,
    output logic        overflow,
    input  logic        clr_overflow,
    output logic [15:0] drop_cnt
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    state_t            r_state;
    state_t            w_state_next;
    logic              r_frame_done;
    logic              w_frame_done_next;
    logic              r_overflow;
    logic [15:0]       r_drop_cnt;

    logic              w_accept;
    logic              w_pop;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic              w_sof;
    logic              w_eol;
    logic              w_eof;
    beat_t             w_beat_in;
    beat_t             w_beat_out;
    logic [BEAT_W-1:0] w_fifo_dout;

    // Pixels arriving during reset are discarded, not counted.
    assign w_accept  = pix_valid && !rst;
    assign w_sof     = (r_col == '0) && (r_row == '0);
    assign w_eol     = (r_col == COL_W'(IMG_W - 1));
    assign w_eof     = w_eol && (r_row == ROW_W'(IMG_H - 1));
    assign w_beat_in = {pix_in, w_sof, w_eol, w_eof};
    assign w_pop     = m_valid && m_ready;
    assign w_drop    = w_accept && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (w_beat_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_beat_out = beat_t'(w_fifo_dout);
    assign m_valid    = !w_empty;
    assign m_data     = w_beat_out.data;
    // Tags are forced low while empty so reset leaves them at zero.
    assign m_sof      = m_valid && w_beat_out.sof;
    assign m_eol      = m_valid && w_beat_out.eol;
    assign m_eof      = m_valid && w_beat_out.eof;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

    // Raster position advances on every accepted pixel, dropped or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_eol) begin
                r_col <= '0;
                r_row <= w_eof ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_frame_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // A one-pixel frame completes without leaving IDLE.
                    if (w_eof) w_frame_done_next = 1'b1;
                    else       w_state_next      = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_accept && w_eof) begin
                    w_state_next      = ST_IDLE;
                    w_frame_done_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_overflow)               r_drop_cnt <= 16'd1;
            else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pixel_stream_framer.sv
module tb_pixel_stream_framer;

    logic        clk;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic [7:0]  m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic        m_valid;
    logic        m_ready;
    logic        frame_done;
    logic        overflow;
    logic        clr_overflow;
    logic [15:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;

    logic [10:0] exp_q[$];

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } vec_t;

    vec_t vecs[24];

    pixel_stream_framer #(
        .IMG_W      (4),
        .IMG_H      (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .m_data       (m_data),
        .m_sof        (m_sof),
        .m_eol        (m_eol),
        .m_eof        (m_eof),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_cnt     (drop_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [10:0] mk(input logic [7:0] d, input logic s,
                                       input logic l, input logic f);
        return {d, s, l, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        pix_in    = v;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic do_reset();
        m_ready      = 1'b0;
        clr_overflow = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int k = 0; k < 20 && (m_valid || exp_q.size() != 0); k++) tick();
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_m_valid_low"}, m_valid, 0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && frame_done) fd_cnt++;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", mk(m_data, m_sof, m_eol, m_eof), 11'h7FF);
            end else begin
                check("beat", mk(m_data, m_sof, m_eol, m_eof), exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] held;
        int          n;

        rst          = 1'b1;
        pix_in       = 8'h00;
        pix_valid    = 1'b0;
        m_ready      = 1'b0;
        clr_overflow = 1'b0;

        // Vector table: two back-to-back 4x3 frames, pixel value = index.
        for (int i = 0; i < 24; i++) begin
            vecs[i].pix = 8'(i);
            vecs[i].sof = (i % 12 == 0);
            vecs[i].eol = (i % 4 == 3);
            vecs[i].eof = (i % 12 == 11);
        end

        // Reset state
        pix_valid = 1'b1;
        tick();
        tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_tags", {m_sof, m_eol, m_eof}, 0);
        pix_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_m_valid", m_valid, 0);

        // Two frames back to back with m_ready=1
        m_ready = 1'b1;
        fd_cnt  = 0;
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(mk(vecs[i].pix, vecs[i].sof, vecs[i].eol, vecs[i].eof));
            send(vecs[i].pix);
            if (i == 0) begin
                check("latency_m_valid", m_valid, 1);
                check("latency_m_data", m_data, 0);
            end
            check($sformatf("frame_done_%0d", i), frame_done, vecs[i].eof);
        end
        drain("stream");
        check("frame_done_count", fd_cnt, 2);
        check("stream_overflow", overflow, 0);

        // Stall: 6 pixels into a depth-4 FIFO
        do_reset();
        for (int i = 0; i < 4; i++) send(8'(i));
        held = mk(m_data, m_sof, m_eol, m_eof);
        check("stall_head", held, mk(8'd0, 1'b1, 1'b0, 1'b0));
        send(8'd4);
        send(8'd5);
        check("stall_stable", mk(m_data, m_sof, m_eol, m_eof), held);
        check("stall_overflow", overflow, 1);
        check("stall_drop_cnt", drop_cnt, 2);
        exp_q.push_back(mk(8'd0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(8'd1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'd2, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'd3, 1'b0, 1'b1, 1'b0));
        drain("stall");
        // Raster kept advancing through the drops: col 2 then col 3 of row 1
        exp_q.push_back(mk(8'h66, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'h77, 1'b0, 1'b1, 1'b0));
        send(8'h66);
        send(8'h77);
        drain("after_drop");

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) send(8'(i));
        exp_q.push_back(mk(8'd0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(8'd1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'd2, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'd3, 1'b0, 1'b1, 1'b0));
        m_ready = 1'b1;
        for (int i = 4; i < 7; i++) begin
            exp_q.push_back(mk(8'(i), 1'b0, 1'b0, 1'b0));
            send(8'(i));
            check($sformatf("full_pp_drop_%0d", i), drop_cnt, 0);
        end
        check("full_pp_overflow", overflow, 0);
        n = 0;
        while (m_valid && n < 10) begin
            tick();
            n++;
        end
        check("full_pp_occupancy", n, 4);
        drain("full_pp");

        // Clear and drop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
        clr_overflow = 1'b1;
        send(8'h44);
        clr_overflow = 1'b0;
        check("clr_drop_overflow", overflow, 1);
        check("clr_drop_cnt", drop_cnt, 1);
        send(8'h45);
        check("second_drop_cnt", drop_cnt, 2);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt_zero", drop_cnt, 0);
        exp_q.push_back(mk(8'h10, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'h12, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'h13, 1'b0, 1'b1, 1'b0));
        drain("clr");

        // Reset mid-frame after pixel 5, with pix_valid high during reset
        do_reset();
        for (int i = 0; i < 6; i++) send(8'(i));
        check("pre_rst_overflow", overflow, 1);
        pix_in    = 8'hEE;
        pix_valid = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        pix_valid = 1'b0;
        exp_q.delete();
        check("midrst_m_valid", m_valid, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_drop_cnt", drop_cnt, 0);
        check("midrst_frame_done", frame_done, 0);
        m_ready = 1'b1;
        exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0));
        send(8'hA5);
        drain("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
